rf_param: RTL



---
 rtl/rf_param_if.sv | 39 +++
 rtl/rf_param.sv | 129 ++++++++++++
 2 files changed

// File: rtl/rf_param_if.sv
// Register-file access bundle: clear request, two write ports, two read ports
// and status flags. The master side drives requests, the slave side (the
// register file) returns read data and status.
interface rf_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              clr_req;
    logic              wa_en;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_dat;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_dat;
    logic [ADDR_W-1:0] rd1_addr;
    logic [ADDR_W-1:0] rd2_addr;
    logic [DATA_W-1:0] rd1_dat;
    logic [DATA_W-1:0] rd2_dat;
    logic              busy;
    logic              wr_err;

    modport master (
        output clr_req,
        output wa_en, wa_addr, wa_dat,
        output wb_en, wb_addr, wb_dat,
        output rd1_addr, rd2_addr,
        input  rd1_dat, rd2_dat,
        input  busy, wr_err
    );

    modport slave (
        input  clr_req,
        input  wa_en, wa_addr, wa_dat,
        input  wb_en, wb_addr, wb_dat,
        input  rd1_addr, rd2_addr,
        output rd1_dat, rd2_dat,
        output busy, wr_err
    );
endinterface

// File: rtl/rf_param.sv
// Two-write / two-read register file with a self-clearing sequence.
// After reset (or on a clear request) the array is zeroed one entry per
// cycle; during that time writes are dropped and flagged, reads return 0.
// Optional same-cycle write forwarding and an optional hardwired-zero r0.
module rf_param #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic       CLK,
    input  logic       RST_N,
    rf_param_if.slave  bus
);

    localparam int                NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NREGS - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_wr_err;
    logic [DATA_W-1:0] r_mem [NREGS];

    logic              w_ready;
    logic              w_wr_open;
    logic              w_wa_r0;
    logic              w_wb_r0;
    logic              w_wa_hit;
    logic              w_wb_hit;
    logic [ADDR_W-1:0] w_rd_addr [2];
    logic [DATA_W-1:0] w_rd_dat  [2];

    // Writes only land in READY, and a clear request in the same cycle
    // takes precedence over them (silently, not as an error).
    assign w_ready   = (r_state == ST_READY);
    assign w_wr_open = w_ready && !bus.clr_req;

    // With a hardwired r0, writes to address 0 are discarded quietly.
    assign w_wa_r0  = (ZERO_R0 != 0) && (bus.wa_addr == '0);
    assign w_wb_r0  = (ZERO_R0 != 0) && (bus.wb_addr == '0);

    // Port A owns a shared address; port B is dropped on collision.
    assign w_wa_hit = w_wr_open && bus.wa_en && !w_wa_r0;
    assign w_wb_hit = w_wr_open && bus.wb_en && !w_wb_r0 &&
                      !(bus.wa_en && (bus.wa_addr == bus.wb_addr));

    // Control state: clear sequencer, ready state and sticky write-error flag.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_wr_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (bus.wa_en || bus.wb_en) begin
                        r_wr_err <= 1'b1;
                    end
                    if (r_clr_cnt == LAST) begin
                        r_state   <= ST_READY;
                        r_clr_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    if (bus.clr_req) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= '0;
                    end
                end
                default: begin
                    r_state   <= ST_CLEAR;
                    r_clr_cnt <= '0;
                end
            endcase
        end
    end

    // Storage array: zeroed by the clear walk, otherwise updated by the ports.
    always_ff @(posedge CLK) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_cnt] <= '0;
        end else begin
            if (w_wb_hit) begin
                r_mem[bus.wb_addr] <= bus.wb_dat;
            end
            if (w_wa_hit) begin
                r_mem[bus.wa_addr] <= bus.wa_dat;
            end
        end
    end

    assign w_rd_addr[0] = bus.rd1_addr;
    assign w_rd_addr[1] = bus.rd2_addr;

    // Read muxes: array value, optionally overridden by a committing write
    // (A beats B), then masked for r0 and for the whole clear period.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd_dat[p] = r_mem[w_rd_addr[p]];
            if (BYPASS != 0) begin
                if (w_wb_hit && (bus.wb_addr == w_rd_addr[p])) begin
                    w_rd_dat[p] = bus.wb_dat;
                end
                if (w_wa_hit && (bus.wa_addr == w_rd_addr[p])) begin
                    w_rd_dat[p] = bus.wa_dat;
                end
            end
            if ((ZERO_R0 != 0) && (w_rd_addr[p] == '0)) begin
                w_rd_dat[p] = '0;
            end
            if (!w_ready) begin
                w_rd_dat[p] = '0;
            end
        end
    end

    assign bus.rd1_dat = w_rd_dat[0];
    assign bus.rd2_dat = w_rd_dat[1];
    assign bus.busy    = (r_state == ST_CLEAR);
    assign bus.wr_err  = r_wr_err;

endmodule
